// File: rtl/adder_bist_checker.sv
// adder_bist_checker: sweeps all operand pairs into an adder under test and checks sum/carry against a golden add
module adder_bist_checker #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_carry,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 fail_valid,
    output logic [2*WIDTH-1:0]   first_fail
);
    localparam int VW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t             state_q, state_d;
    logic [VW-1:0]      idx_q, idx_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fv_q, fv_d;
    logic [VW-1:0]      ff_q, ff_d;
    logic [WIDTH:0]     exp_res;
    logic               mismatch;

    assign dut_a      = idx_q[VW-1:WIDTH];
    assign dut_b      = idx_q[WIDTH-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;

    // Golden result and mismatch against the returned sum/carry; APPLY spends SETTLE cycles and CHECK
    // samples on its leaving edge, so each vector gets SETTLE+1 cycles in total.
    always_comb begin
        exp_res  = {1'b0, dut_a} + {1'b0, dut_b};
        mismatch = ({dut_carry, dut_sum} != exp_res);
    end

    // Next-state and output logic for the sweep FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = APPLY;
                busy_d  = 1'b1;
                idx_d   = '0;
                cnt_d   = '0;
                err_d   = '0;
                fv_d    = 1'b0;
                ff_d    = '0;
                pass_d  = 1'b0;
            end
            APPLY: begin
                state_d = (cnt_q == 8'(SETTLE - 1)) ? CHECK : APPLY;
                cnt_d   = (cnt_q == 8'(SETTLE - 1)) ? 8'd0 : cnt_q + 8'd1;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = (&err_q) ? err_q : err_q + ERR_W'(1);
                    fv_d  = 1'b1;
                    ff_d  = fv_q ? ff_q : idx_q;
                end
                idx_d   = idx_q + VW'(1);
                state_d = (&idx_q) ? DONE : APPLY;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
        end
    end
endmodule

// File: tb/tb_adder_bist_checker.sv
// tb_adder_bist_checker: directed checks of the BIST sequencer against modelled good and faulty adders
module tb_adder_bist_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    int   mode = 0;
    int   errors = 0;
    int   checks = 0;
    int   done_seen;

    logic       a1, b1, s1, c1, busy1, done1, pass1, fv1;
    logic [7:0] err1;
    logic [1:0] ff1, r1;
    logic [1:0] a2, b2, s2, err2;
    logic       c2, busy2, done2, pass2, fv2;
    logic [3:0] ff2;
    logic [2:0] r2;

    always #5 clk = ~clk;

    // Modelled adders: mode 0 correct, 1 carry stuck at 0, 2 sum inverted
    assign r1 = {1'b0, a1} + {1'b0, b1};
    assign s1 = (mode == 2) ? ~r1[0] : r1[0];
    assign c1 = (mode == 1) ? 1'b0 : r1[1];
    assign r2 = {1'b0, a2} + {1'b0, b2};
    assign s2 = ~r2[1:0];
    assign c2 = r2[2];

    adder_bist_checker #(.WIDTH(1), .SETTLE(2), .ERR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a1), .dut_b(b1),
        .dut_sum(s1), .dut_carry(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .first_fail(ff1)
    );

    adder_bist_checker #(.WIDTH(2), .SETTLE(2), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_a(a2), .dut_b(b2),
        .dut_sum(s2), .dut_carry(c2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_valid(fv2), .first_fail(ff2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=1 sweep; cycle c counts edges after the accepting edge T0
    task automatic sweep1(input int restart_at, input logic e_pass, input logic [7:0] e_err,
                          input logic e_fv, input logic [1:0] e_ff, input logic [7:0] e_err3);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("c0_busy", busy1, 1'b1);
        chk("c0_err_cleared", err1, 8'd0);
        chk("c0_fv_cleared", fv1, 1'b0);
        chk("c0_vec", {a1, b1}, 2'b00);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == 2) chk("c2_vec_hold", {a1, b1}, 2'b00);
            if (c == 3) chk("c3_vec", {a1, b1}, 2'b01);
            if (c == 3) chk("c3_err_mid", err1, e_err3);
            if (c == 6) chk("c6_vec", {a1, b1}, 2'b10);
            if (c == 9) chk("c9_vec", {a1, b1}, 2'b11);
            if (c == 12) chk("c12_no_done", done1, 1'b0);
            if (c == 12) chk("c12_busy", busy1, 1'b1);
            if (c == 13) begin
                chk("c13_done", done1, 1'b1);
                chk("c13_busy_low", busy1, 1'b0);
                chk("c13_pass", pass1, e_pass);
                chk("c13_err", err1, e_err);
                chk("c13_fv", fv1, e_fv);
                chk("c13_ff", ff1, e_ff);
                chk("c13_vec_zero", {a1, b1}, 2'b00);
            end
            if (c == 14) chk("c14_done_pulse", done1, 1'b0);
        end
        start = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_pass", pass1, 1'b0);
        chk("rst_err", err1, 8'd0);
        chk("rst_fv", fv1, 1'b0);
        chk("rst_ff", ff1, 2'b00);
        chk("rst_vec", {a1, b1}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        mode = 0;
        sweep1(0, 1'b1, 8'd0, 1'b0, 2'b00, 8'd0);
        mode = 1;
        sweep1(0, 1'b0, 8'd1, 1'b1, 2'b11, 8'd0);
        mode = 2;
        sweep1(0, 1'b0, 8'd4, 1'b1, 2'b00, 8'd1);
        mode = 0;
        sweep1(5, 1'b1, 8'd0, 1'b0, 2'b00, 8'd0);

        // Reset mid-sweep with a failing adder so err_count is nonzero before the reset
        mode = 2;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_err", err1, 8'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec", {a1, b1}, 2'b00);
        chk("mid_rst_busy", busy1, 1'b0);
        chk("mid_rst_err", err1, 8'd0);
        chk("mid_rst_fv", fv1, 1'b0);
        chk("mid_rst_ff", ff1, 2'b00);
        chk("mid_rst_pass", pass1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done1 || busy1) done_seen++;
        end
        chk("no_done_after_rst", done_seen, 0);
        mode = 0;
        sweep1(0, 1'b1, 8'd0, 1'b0, 2'b00, 8'd0);

        // WIDTH=2, ERR_W=2, every vector wrong: saturation and 49-cycle completion
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            if (c == 3) chk("w2_c3_err", err2, 2'd1);
            if (c == 9) chk("w2_c9_err", err2, 2'd3);
            if (c == 12) chk("w2_c12_sat", err2, 2'd3);
            if (c == 12) chk("w2_c12_vec", {a2, b2}, 4'd4);
            if (c == 48) chk("w2_c48_no_done", done2, 1'b0);
            if (c == 49) begin
                chk("w2_done", done2, 1'b1);
                chk("w2_err_sat", err2, 2'd3);
                chk("w2_ff", ff2, 4'd0);
                chk("w2_fv", fv2, 1'b1);
                chk("w2_pass", pass2, 1'b0);
            end
        end
        chk("w1_idle_during_w2", busy1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
